// File: rtl/lsu_bus_unit.sv
// Load/store unit: turns one MA-stage load/store into a handshaked,
// word-aligned bus transaction with byte enables, and returns
// lane-shifted, sign/zero-extended load data with a one-cycle response.
module lsu_bus_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW           = $clog2(TIMEOUT + 1);
  localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic          err_q;

  logic [31:0] offset;
  logic        f3_bad, misal, oor, req_err;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [31:0] shifted, ld_data;
  logic        timeout;

  // Request decode: error classification and bus lane pattern for the incoming request
  always_comb begin
    offset  = req_addr - BASE_ADDR;
    f3_bad  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
              (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // Unsigned wrap makes addresses below BASE_ADDR fail too
    oor     = (offset >= WINDOW_BYTES);
    req_err = f3_bad || misal || oor;
    be_in   = 4'b1111;
    wd_in   = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_in = 4'b0001 << req_addr[1:0];
        wd_in = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_in = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_in = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_we) wd_in = '0;
  end

  // Load return path: shift addressed lane to bit 0, then extend by width/sign
  always_comb begin
    shifted = bus_rdata >> {lane_q, 3'b000};
    ld_data = shifted;
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = f3_q[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    timeout = (cnt == CW'(TIMEOUT - 1));
    case (state)
      IDLE: if (req_valid) state_n = req_err ? RESP : BUS;
      BUS:  if (bus_ready || timeout) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Datapath registers: latched request, bus drive, wait counter, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      f3_q       <= '0;
      lane_q     <= '0;
      err_q      <= 1'b0;
      resp_rdata <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            f3_q       <= req_funct3;
            lane_q     <= req_addr[1:0];
            err_q      <= req_err;
            resp_rdata <= '0;
            if (!req_err) begin
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= be_in;
              bus_wdata <= wd_in;
            end
          end
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          // A ready in the final allowed cycle wins over the timeout
          if (bus_ready) begin
            err_q <= 1'b0;
            if (!bus_we) resp_rdata <= ld_data;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign req_ready  = rst && (state == IDLE);
  assign stall      = (state == BUS);
  assign bus_valid  = (state == BUS);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_lsu_bus_unit.sv
// Directed bench for lsu_bus_unit: loads, stores, error paths, timeout and
// mid-transaction reset, with hand-computed expected values.
module tb_lsu_bus_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;

  lsu_bus_unit #(
    .BASE_ADDR  (32'h10010000),
    .DEPTH_WORDS(1024),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .stall     (stall),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, confirm the unit is ready, and take the accept edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Request that must be rejected: response one cycle after accept, no bus activity
  task automatic err_case(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3);
    issue(we, addr, f3, 32'h0);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_resp_err"},   {31'b0, resp_err},   32'd1);
    chk({tag, "_bus_valid"},  {31'b0, bus_valid},  32'd0);
    chk({tag, "_rdata"},      resp_rdata,          32'h0);
    tick();
    chk({tag, "_back_idle"},  {31'b0, req_ready},  32'd1);
  endtask

  int hi_cnt;

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_req_ready",  {31'b0, req_ready},  32'd0);
    chk("rst_bus_valid",  {31'b0, bus_valid},  32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_stall",      {31'b0, stall},      32'd0);
    chk("rst_bus_addr",   bus_addr,            32'h0);
    chk("rst_bus_be",     {28'b0, bus_be},     32'h0);
    chk("rst_resp_rdata", resp_rdata,          32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ---------------- LW with two wait cycles ----------------
    issue(1'b0, 32'h10010008, 3'b010, 32'h0);
    chk("lw_bus_valid", {31'b0, bus_valid}, 32'd1);
    chk("lw_stall",     {31'b0, stall},     32'd1);
    chk("lw_bus_addr",  bus_addr,           32'h10010008);
    chk("lw_bus_be",    {28'b0, bus_be},    32'h0000000F);
    chk("lw_bus_we",    {31'b0, bus_we},    32'd0);
    chk("lw_req_ready_busy", {31'b0, req_ready}, 32'd0);
    tick();
    chk("lw_wait2_valid", {31'b0, bus_valid}, 32'd1);
    chk("lw_wait2_resp",  {31'b0, resp_valid}, 32'd0);
    tick();
    bus_ready = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    chk("lw_wait3_valid", {31'b0, bus_valid}, 32'd1);
    tick();
    bus_ready = 1'b0;
    chk("lw_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("lw_resp_rdata", resp_rdata,          32'hDEADBEEF);
    chk("lw_resp_err",   {31'b0, resp_err},   32'd0);
    chk("lw_resp_stall", {31'b0, stall},      32'd0);
    chk("lw_resp_ready", {31'b0, req_ready},  32'd0);
    tick();
    chk("lw_resp_pulse", {31'b0, resp_valid}, 32'd0);

    // ---------------- LB / LBU top byte ----------------
    issue(1'b0, 32'h10010003, 3'b000, 32'h0);
    chk("lb_bus_be", {28'b0, bus_be}, 32'h00000008);
    bus_ready = 1'b1;
    bus_rdata = 32'h80FF0000;
    tick();
    bus_ready = 1'b0;
    chk("lb_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("lb_rdata",      resp_rdata,          32'hFFFFFF80);
    tick();
    issue(1'b0, 32'h10010003, 3'b100, 32'h0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    tick();

    // ---------------- LH sign extend, lower half ----------------
    issue(1'b0, 32'h10010000, 3'b001, 32'h0);
    chk("lh_bus_be", {28'b0, bus_be}, 32'h00000003);
    bus_ready = 1'b1;
    bus_rdata = 32'h1234F00D;
    tick();
    bus_ready = 1'b0;
    chk("lh_rdata", resp_rdata, 32'hFFFFF00D);
    tick();

    // ---------------- SH upper half, zero-wait ----------------
    issue(1'b1, 32'h10010006, 3'b001, 32'h0000ABCD);
    chk("sh_bus_addr",  bus_addr,           32'h10010004);
    chk("sh_bus_be",    {28'b0, bus_be},    32'h0000000C);
    chk("sh_bus_wdata", bus_wdata,          32'hABCDABCD);
    chk("sh_bus_we",    {31'b0, bus_we},    32'd1);
    bus_ready = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_ready = 1'b0;
    chk("sh_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("sh_resp_rdata", resp_rdata,          32'h0);
    chk("sh_resp_err",   {31'b0, resp_err},   32'd0);
    tick();

    // ---------------- SB lane 1 replicate ----------------
    issue(1'b1, 32'h10010FFD, 3'b000, 32'h12345678);
    chk("sb_bus_be",    {28'b0, bus_be}, 32'h00000002);
    chk("sb_bus_wdata", bus_wdata,       32'h78787878);
    chk("sb_bus_addr",  bus_addr,        32'h10010FFC);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("sb_resp_err", {31'b0, resp_err}, 32'd0);
    tick();

    // ---------------- error paths ----------------
    err_case("misaligned_lw", 1'b0, 32'h10010001, 3'b010);
    err_case("below_base_sw", 1'b1, 32'h0FFFFFFC, 3'b010);
    err_case("funct3_011",    1'b0, 32'h10010000, 3'b011);
    err_case("past_end_lw",   1'b0, 32'h10011000, 3'b010);
    err_case("store_unsigned", 1'b1, 32'h10010000, 3'b100);
    err_case("misaligned_lh", 1'b0, 32'h10010003, 3'b101);

    // ---------------- timeout: bus never ready ----------------
    issue(1'b0, 32'h10010010, 3'b010, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 20 && bus_valid; i++) begin
      hi_cnt++;
      tick();
    end
    chk("to_bus_valid_cycles", 32'(hi_cnt),        32'd16);
    chk("to_resp_valid",       {31'b0, resp_valid}, 32'd1);
    chk("to_resp_err",         {31'b0, resp_err},   32'd1);
    chk("to_resp_rdata",       resp_rdata,          32'h0);
    tick();

    // ---------------- ready in the last allowed cycle ----------------
    issue(1'b0, 32'h10010014, 3'b010, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("late_still_bus", {31'b0, bus_valid}, 32'd1);
    bus_ready = 1'b1;
    bus_rdata = 32'h12345678;
    tick();
    bus_ready = 1'b0;
    chk("late_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("late_resp_err",   {31'b0, resp_err},   32'd0);
    chk("late_resp_rdata", resp_rdata,          32'h12345678);
    tick();

    // ---------------- reset during BUS ----------------
    issue(1'b0, 32'h10010020, 3'b010, 32'h0);
    tick();
    chk("mid_rst_pre_valid", {31'b0, bus_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bus_valid",  {31'b0, bus_valid},  32'd0);
    chk("mid_rst_req_ready",  {31'b0, req_ready},  32'd0);
    chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_rst_req_ready",  {31'b0, req_ready},  32'd1);
    issue(1'b0, 32'h10010024, 3'b010, 32'h0);
    chk("post_rst_bus_addr", bus_addr, 32'h10010024);
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ready = 1'b0;
    chk("post_rst_lw_valid", {31'b0, resp_valid}, 32'd1);
    chk("post_rst_lw_rdata", resp_rdata,          32'hCAFEF00D);
    chk("post_rst_lw_err",   {31'b0, resp_err},   32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
